// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing an asynchronous FIFO's write port among 2**id_width requesters
// in the write clock domain. A grantee may write up to burst_len words per grant. Writes are
// held off while the FIFO reports full. A saturating counter records the cycles lost to a
// full FIFO.
//
// Ports:
//   clk        write-domain clock (same net as FIFO wclk)
//   rstn       asynchronous active-low reset (same net as FIFO wrst_n)
//   req_valid  per-requester valid
//   req_data   per-requester data, requester i at [i*datawidth +: datawidth]
//   req_ready  per-requester accept, only the grantee's bit can be high
//   wfull      FIFO full flag
//   wdata      FIFO write data, zero outside a grant
//   winc       FIFO write strobe
//   grant_id   current or most recent grantee
//   busy       grant held
//   stall_cnt  saturating count of cycles stalled on wfull
module fifo_wr_arbiter #(
   parameter int unsigned datawidth   = 8,
   parameter int unsigned id_width    = 2,
   parameter int unsigned burst_len   = 4,
   parameter int unsigned stall_width = 16
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic [(1<<id_width)-1:0]              req_valid,
   input  logic [(1<<id_width)*datawidth-1:0]    req_data,
   output logic [(1<<id_width)-1:0]              req_ready,
   input  logic                                  wfull,
   output logic [datawidth-1:0]                  wdata,
   output logic                                  winc,
   output logic [id_width-1:0]                   grant_id,
   output logic                                  busy,
   output logic [stall_width-1:0]                stall_cnt
);

   localparam int unsigned num_req = 1 << id_width;
   localparam int unsigned burst_w = $clog2(burst_len + 1);
   localparam logic [burst_w-1:0] burst_last = burst_w'(burst_len - 1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e                 state_q;
   logic [id_width-1:0]    grant_id_q;
   logic [burst_w-1:0]     burst_cnt_q;
   logic [stall_width-1:0] stall_cnt_q;

   logic                   sel_valid;
   logic [id_width-1:0]    sel_id;
   logic [id_width-1:0]    cand;
   logic                   g_valid;

   assign g_valid = req_valid[grant_id_q];

   // Search starts one past the last grantee; the final candidate wraps back to the last
   // grantee itself, so a lone requester is re-granted.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = grant_id_q;
      cand      = '0;
      for (int unsigned k = 1; k <= num_req; k++) begin
         cand = grant_id_q + id_width'(k);
         if (!sel_valid && req_valid[cand]) begin
            sel_valid = 1'b1;
            sel_id    = cand;
         end
      end
   end

   // Write-side outputs are combinational so wfull can gate winc within the same cycle.
   always_comb begin
      req_ready = '0;
      winc      = 1'b0;
      wdata     = '0;
      if (state_q == StGrant) begin
         req_ready[grant_id_q] = ~wfull;
         winc                  = g_valid & ~wfull;
         wdata                 = req_data[grant_id_q*datawidth +: datawidth];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         grant_id_q  <= '1;
         burst_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sel_valid) begin
                  state_q     <= StGrant;
                  grant_id_q  <= sel_id;
                  burst_cnt_q <= '0;
               end
            end
            StGrant: begin
               if (!g_valid) begin
                  // Requester released: no transfer this cycle.
                  state_q <= StIdle;
               end else if (wfull) begin
                  if (stall_cnt_q != '1) begin
                     stall_cnt_q <= stall_cnt_q + stall_width'(1);
                  end
               end else begin
                  burst_cnt_q <= burst_cnt_q + burst_w'(1);
                  if (burst_cnt_q == burst_last) begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign grant_id  = grant_id_q;
   assign busy      = (state_q == StGrant);
   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the asynchronous FIFO's write port among several requesters in the write clock domain. Each requester presents data with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and drives the FIFO's `wdata`/`winc`, honouring `wfull`. It also keeps a saturating count of cycles lost to back-pressure from a full FIFO.

## Interface
Parameters:
- `datawidth`, 8: FIFO data width; must match the FIFO instance.
- `id_width`, 2: requester index width; number of requesters `num_req` = 2**`id_width`.
- `burst_len`, 4: maximum writes per grant; must be ≥1.
- `stall_width`, 16: width of the stall counter.

Ports:
- `clk` in 1: write-domain clock; same net as the FIFO's `wclk`.
- `rstn` in 1: reset, asynchronous, active-low; same net as the FIFO's `wrst_n`.
- `req_valid` in `num_req`: bit i is the request from requester i.
- `req_data` in `num_req`*`datawidth`: requester i's data is at `[i*datawidth +: datawidth]`.
- `req_ready` out `num_req`: bit i accepts requester i's current word.
- `wfull` in 1: full flag from the FIFO write side.
- `wdata` out `datawidth`: to the FIFO `wdata`.
- `winc` out 1: to the FIFO `winc`.
- `grant_id` out `id_width`: index of the current or most recent grantee.
- `busy` out 1: high while a grant is held (state GRANT).
- `stall_cnt` out `stall_width`: saturating count of full-stall cycles.

## Operation
- The FSM has two states, IDLE and GRANT. Registers are `state`, `grant_id`, `burst_cnt` (ceil(log2(`burst_len`+1)) bits) and `stall_cnt`.
- IDLE:
  - If any `req_valid` bit is set, select the first valid index searching (`grant_id`+1) mod `num_req`, then upward with wrap.
  - Register the selection into `grant_id`, clear `burst_cnt`, and go to GRANT.
  - No transfer occurs in an IDLE cycle; `req_ready`=0 and `winc`=0.
  - If no `req_valid` bit is set, stay in IDLE.
- GRANT, with g = `grant_id`:
  - `req_ready[g]` = ~`wfull`. All other `req_ready` bits are 0.
  - `winc` = `req_valid[g]` & ~`wfull`.
  - `wdata` = slice g of `req_data`.
  - A transfer is `winc`=1 at a rising `clk`. A transfer increments `burst_cnt`.
- Leaving GRANT for IDLE:
  - Leave on a transfer when `burst_cnt` == `burst_len`-1 (burst complete).
  - Leave on any cycle where `req_valid[g]`=0 (requester released); no transfer occurs that cycle.
  - Otherwise stay in GRANT, including all cycles where `wfull`=1.
- Round-robin rotates from the last grantee, so a requester that stays valid after its burst yields to any other valid requester. If it is the only valid requester, it is re-granted after one IDLE cycle.
- Handshake rule: a requester holds `req_valid` high and `req_data` stable until it sees `req_ready` high at a clock edge. A requester may deassert `req_valid` only when it has nothing to send.
- `wdata` is 0 whenever the state is not GRANT.
- `stall_cnt` increments in GRANT when `req_valid[g]`=1 and `wfull`=1. It saturates at all-ones and never wraps. It clears only on reset.
- `wfull` rising mid-burst stalls the burst. Stalled cycles do not count toward `burst_len`, and the grant is kept until the burst completes or valid drops.

## Timing
- Reset (asynchronous, immediate):
  - `state`=IDLE, `grant_id`=`num_req`-1 (first search starts at 0), `burst_cnt`=0, `stall_cnt`=0.
  - Outputs: `winc`=0, `req_ready`=0, `wdata`=0, `busy`=0.
  - Asserting reset mid-burst drops `winc` in the same cycle, without waiting for a clock edge.
- Arbitration latency: the first transfer happens at the second rising edge after `req_valid` rises, provided the arbiter was in IDLE and `wfull`=0.
- Sustained throughput for one requester: `burst_len` writes per `burst_len`+1 cycles.
- `winc`, `req_ready` and `wdata` are combinational from registered state plus `req_valid`, `req_data` and `wfull`. There is no combinational path from `req_data` to any control output.
- The `wfull` path: FIFO pointer registers → `wfull` → `winc` → FIFO write enable, all within one `clk` cycle.
- `grant_id` updates on the IDLE→GRANT edge and holds through IDLE.
- `busy` equals (`state`==GRANT).

## Test plan
- Reset, then requester 0 holds valid with data 0x11,0x22,… and `wfull`=0 → `grant_id`=0; writes on cycles 2–5 (0x11..0x44); 1 idle cycle; writes 0x55..0x88 on cycles 7–10.
- All four requesters continuously valid → grants go 0,1,2,3,0 in order, each burst exactly 4 `winc` pulses, each `wdata` taken from the granted slice, and exactly one `req_ready` bit high at a time.
- Requester 2 granted, FIFO goes full after 2 writes for 5 cycles → `winc`=0 and `req_ready[2]`=0 during the stall; `stall_cnt` advances by 5; the remaining 2 writes complete after `wfull` drops; then the arbiter returns to IDLE.
- Requester 1 drops valid after 1 write → arbiter returns to IDLE in that cycle; the next grant goes to the next valid index after 1.
- Force `stall_cnt` near saturation (`stall_width`=4, 20 stall cycles) → it stops at 0xF.
- Assert `rstn` low mid-burst between clock edges → `winc`, `req_ready` and `busy` drop immediately; after release, the first grant goes to requester 0.
